// File: rtl/xc20xx_lut_cfg_loader_if.sv
// Serial config bus between the configuration controller and the LUT loader.
// Controller drives the gated bitstream; loader returns INIT tables and status.
interface xc20xx_lut_cfg_loader_if #(
   parameter int NUM_LUTS = 4
);
   logic                    din;
   logic                    din_valid;
   logic                    restart;
   logic [16*NUM_LUTS-1:0]  init_flat;
   logic                    busy;
   logic                    done;
   logic                    err;

   modport master (
      output din, din_valid, restart,
      input  init_flat, busy, done, err
   );

   modport slave (
      input  din, din_valid, restart,
      output init_flat, busy, done, err
   );
endinterface

// File: rtl/xc20xx_lut_cfg_loader.sv
// XC20XX LUT4 INIT loader: sync hunt, framed 16-bit words with stop bit,
// whole-slot commit into the INIT bus, DONE/ERR status.
module xc20xx_lut_cfg_loader #(
   parameter int          NUM_LUTS = 4,
   parameter logic [7:0]  SYNC     = 8'hF2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   xc20xx_lut_cfg_loader_if.slave cfg
);
   localparam int FW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
   localparam logic [FW-1:0] LAST = FW'(NUM_LUTS - 1);

   typedef enum logic [2:0] {
      S_HUNT,
      S_DATA,
      S_STOP,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [7:0]       win;
   logic [7:0]       win_nx;
   logic [15:0]      shadow;
   logic [3:0]       bit_cnt;
   logic [FW-1:0]    frame_idx;
   logic [15:0]      slot [NUM_LUTS];
   logic             sync_hit;
   logic             last;

   assign win_nx   = {win[6:0], cfg.din};
   assign sync_hit = (win_nx == SYNC);
   assign last     = (frame_idx == LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_HUNT;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: restart wins, otherwise advance only on valid bits.
   always_comb begin
      state_nx = state;
      if (cfg.restart) begin
         state_nx = S_HUNT;
      end else if (cfg.din_valid) begin
         unique case (state)
            S_HUNT:  if (sync_hit) state_nx = S_DATA;
            S_DATA:  if (bit_cnt == 4'd15) state_nx = S_STOP;
            S_STOP: begin
               if (!cfg.din)  state_nx = S_ERROR;
               else if (last) state_nx = S_DONE;
               else           state_nx = S_DATA;
            end
            default: state_nx = state;
         endcase
      end
   end

   // Sync window, shadow word, counters and committed INIT slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win       <= '0;
         shadow    <= '0;
         bit_cnt   <= '0;
         frame_idx <= '0;
         for (int i = 0; i < NUM_LUTS; i++) slot[i] <= '0;
      end else if (cfg.restart) begin
         win       <= '0;
         shadow    <= '0;
         bit_cnt   <= '0;
         frame_idx <= '0;
      end else if (cfg.din_valid) begin
         unique case (state)
            S_HUNT: begin
               if (sync_hit) begin
                  win       <= '0;
                  bit_cnt   <= '0;
                  frame_idx <= '0;
               end else begin
                  win <= win_nx;
               end
            end
            S_DATA: begin
               shadow  <= {shadow[14:0], cfg.din};
               bit_cnt <= bit_cnt + 4'd1;
            end
            S_STOP: begin
               if (cfg.din) begin
                  for (int i = 0; i < NUM_LUTS; i++) begin
                     if (frame_idx == FW'(i)) slot[i] <= shadow;
                  end
                  if (!last) begin
                     frame_idx <= frame_idx + 1'b1;
                     bit_cnt   <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign cfg.busy = (state == S_DATA) || (state == S_STOP);
   assign cfg.done = (state == S_DONE);
   assign cfg.err  = (state == S_ERROR);

   for (genvar g = 0; g < NUM_LUTS; g++) begin : g_flat
      assign cfg.init_flat[16*g +: 16] = slot[g];
   end
endmodule

// File: tb/tb_xc20xx_lut_cfg_loader.sv
// Bench for xc20xx_lut_cfg_loader with NUM_LUTS=2: directed plan steps
// plus randomized loads checked against a frame-level expectation model.
module tb_xc20xx_lut_cfg_loader;
   localparam int N = 2;
   localparam logic [7:0] SYNC = 8'hF2;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic [15:0] exp_slot [N];
   logic        exp_done;
   logic        exp_err;

   xc20xx_lut_cfg_loader_if #(.NUM_LUTS(N)) bus ();

   xc20xx_lut_cfg_loader #(.NUM_LUTS(N), .SYNC(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cfg   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_flat();
      return {exp_slot[1], exp_slot[0]};
   endfunction

   task automatic send_bit(input logic b, input bit stall);
      int gap;
      logic [34:0] snap;
      gap = stall ? $urandom_range(0, 3) : 0;
      snap = {bus.busy, bus.done, bus.err, bus.init_flat};
      repeat (gap) begin
         @(negedge clk);
         bus.din       = 1'($urandom);
         bus.din_valid = 1'b0;
      end
      if (gap > 0) begin
         @(negedge clk);
         chk("stall_hold", {bus.busy, bus.done, bus.err, bus.init_flat}, snap);
      end
      @(negedge clk);
      bus.din       = b;
      bus.din_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input bit stall);
      for (int i = 15; i >= 0; i--) send_bit(w[i], stall);
   endtask

   task automatic send_sync(input bit stall);
      for (int i = 7; i >= 0; i--) send_bit(SYNC[i], stall);
   endtask

   task automatic do_restart();
      @(negedge clk);
      bus.restart   = 1'b1;
      bus.din_valid = 1'b1;
      bus.din       = 1'b1;
      @(posedge clk);
      #1;
      bus.restart   = 1'b0;
      bus.din_valid = 1'b0;
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_flat"}, 64'(bus.init_flat), 64'(exp_flat()));
      chk({tag, "_done"}, 64'(bus.done), 64'(exp_done));
      chk({tag, "_err"},  64'(bus.err),  64'(exp_err));
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      logic [15:0] w [N];
      logic        stp [N];
      bit          st;
      n_tests = 0;
      n_fail  = 0;
      bus.din = 1'b0;
      bus.din_valid = 1'b0;
      bus.restart = 1'b0;
      for (int i = 0; i < N; i++) exp_slot[i] = '0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_status("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // nominal load
      send_sync(1'b0);
      chk("nom_busy_sync", 64'(bus.busy), 64'd1);
      send_word(16'hA5C3, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("nom_busy_f0", 64'(bus.busy), 64'd1);
      chk("nom_slot0", 64'(bus.init_flat[15:0]), 64'hA5C3);
      send_word(16'h8001, 1'b0);
      chk("nom_busy_pre", 64'(bus.busy), 64'd1);
      chk("nom_done_pre", 64'(bus.done), 64'd0);
      send_bit(1'b1, 1'b0);
      exp_slot[0] = 16'hA5C3;
      exp_slot[1] = 16'h8001;
      exp_done = 1'b1;
      chk_status("nom");

      // same stream with random stalls
      do_restart();
      chk("rst_done", 64'(bus.done), 64'd0);
      send_sync(1'b1);
      send_word(16'hA5C3, 1'b1);
      send_bit(1'b1, 1'b1);
      send_word(16'h8001, 1'b1);
      send_bit(1'b1, 1'b1);
      chk_status("stall");

      // stop-bit error from a freshly reset loader
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      exp_slot[0] = '0;
      exp_slot[1] = '0;
      send_sync(1'b0);
      send_word(16'hFFFF, 1'b0);
      send_bit(1'b1, 1'b0);
      send_word(16'h1234, 1'b0);
      send_bit(1'b0, 1'b0);
      exp_slot[0] = 16'hFFFF;
      exp_done = 1'b0;
      exp_err  = 1'b1;
      chk_status("stoperr");
      send_sync(1'b0);
      for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
      chk_status("stoperr_ign");

      // noisy sync hunt: match exactly on final bit
      do_restart();
      exp_err = 1'b0;
      begin
         logic [11:0] nb;
         nb = 12'b0110_1111_0010;
         for (int i = 11; i >= 1; i--) send_bit(nb[i], 1'b0);
         chk("hunt_pre", 64'(bus.busy), 64'd0);
         send_bit(nb[0], 1'b0);
         chk("hunt_hit", 64'(bus.busy), 64'd1);
      end
      send_word(16'h0F0F, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("hunt_slot0", 64'(bus.init_flat[15:0]), 64'h0F0F);
      send_word(16'h3C3C, 1'b0);
      send_bit(1'b1, 1'b0);
      exp_slot[0] = 16'h0F0F;
      exp_slot[1] = 16'h3C3C;
      exp_done = 1'b1;
      chk_status("hunt");

      // RESTART mid-frame, then a complete second load
      do_restart();
      exp_done = 1'b0;
      send_sync(1'b0);
      send_word(16'h1111, 1'b0);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
      do_restart();
      exp_slot[0] = 16'h1111;
      chk_status("mid_rst");
      send_sync(1'b0);
      send_word(16'hBEEF, 1'b0);
      send_bit(1'b1, 1'b0);
      send_word(16'hCAFE, 1'b0);
      send_bit(1'b1, 1'b0);
      exp_slot[0] = 16'hBEEF;
      exp_slot[1] = 16'hCAFE;
      exp_done = 1'b1;
      chk_status("reload");

      // async reset between edges, mid-load
      do_restart();
      send_sync(1'b0);
      send_word(16'h7777, 1'b0);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_slot[0] = '0;
      exp_slot[1] = '0;
      exp_done = 1'b0;
      chk_status("async");
      @(negedge clk);
      rst_n = 1'b1;
      send_sync(1'b0);
      send_word(16'h5A5A, 1'b0);
      send_bit(1'b1, 1'b0);
      send_word(16'hC001, 1'b0);
      send_bit(1'b1, 1'b0);
      exp_slot[0] = 16'h5A5A;
      exp_slot[1] = 16'hC001;
      exp_done = 1'b1;
      chk_status("post_rst");

      // randomized loads with occasional bad stop bits
      for (int t = 0; t < 8; t++) begin
         st = 1'($urandom);
         for (int f = 0; f < N; f++) begin
            w[f]   = 16'($urandom);
            stp[f] = ($urandom_range(0, 3) != 0);
         end
         exp_done = 1'b1;
         exp_err  = 1'b0;
         for (int f = 0; f < N; f++) begin
            if (!exp_err) begin
               if (stp[f]) begin
                  exp_slot[f] = w[f];
               end else begin
                  exp_err  = 1'b1;
                  exp_done = 1'b0;
               end
            end
         end
         do_restart();
         send_sync(st);
         for (int f = 0; f < N; f++) begin
            send_word(w[f], st);
            send_bit(stp[f], st);
            if (!stp[f]) break;
         end
         for (int i = 0; i < 4; i++) send_bit(1'($urandom), st);
         chk_status($sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/xc20xx_lut_cfg_loader.md
# xc20xx_lut_cfg_loader

Serial configuration loader that sits directly upstream of the XC20XX 4-input LUT cells and produces their 16-bit INIT truth tables. It hunts a sync pattern in a gated serial bitstream, then receives NUM_LUTS framed 16-bit words with stop-bit checking. It commits each word to the INIT bus of the LUT it targets. DONE/ERR report load status to the configuration controller.

## Interface
- NUM_LUTS, 4, number of LUT4 cells configured; must be >= 1
- SYNC, 8'hF2, 8-bit sync pattern; bits arrive MSB first
- CLK  in  1  rising-edge clock for all state
- RST_N  in  1  asynchronous, active-low reset
- DIN  in  1  serial config bit
- DIN_VALID  in  1  DIN is sampled only on edges where this is 1
- RESTART  in  1  synchronous; returns FSM to HUNT from any state
- INIT_FLAT  out  16*NUM_LUTS  LUT i truth table at [16*i+15:16*i]
- BUSY  out  1  high in DATA and STOP states
- DONE  out  1  all frames loaded successfully
- ERR  out  1  stop-bit error detected

## Operation
- States: HUNT, DATA, STOP, DONE, ERROR.
- HUNT:
  - 8-bit window W shifts left on each valid bit: W <= {W[6:0], DIN}.
  - If {W[6:0], DIN} == SYNC, go to DATA with bit_cnt=0, frame_idx=0, and clear W.
- DATA:
  - Each valid bit shifts into 16-bit shadow S, MSB first: S <= {S[14:0], DIN}. The first bit received ends up in INIT[15].
  - After the 16th valid bit (bit_cnt==15), go to STOP.
- STOP:
  - A valid bit of 1 writes S to slot frame_idx of INIT_FLAT.
  - If frame_idx == NUM_LUTS-1, go to DONE. Otherwise increment frame_idx, clear bit_cnt, and go to DATA.
  - A valid bit of 0 goes to ERROR with no commit. INIT_FLAT slot frame_idx keeps its old value.
- DONE and ERROR are terminal and ignore DIN. Only RESTART or reset leaves them.
- RESTART:
  - Takes priority over any DIN handling on the same edge.
  - Goes to HUNT; clears W, S, bit_cnt, frame_idx, DONE, ERR.
  - INIT_FLAT is not cleared; slots keep their values until overwritten by a committed frame.
- A partial load aborted by RESTART leaves already-committed slots updated and the rest unchanged.
- Slots are only ever written whole, never partially.
- frame_idx width is clog2(NUM_LUTS), minimum 1. bit_cnt is 4 bits. Neither counter wraps in normal operation; the STOP and DONE transitions bound them.

## Timing
- Reset values (RST_N low, asynchronous): state=HUNT, W=0, S=0, counters=0, INIT_FLAT all 0, BUSY=0, DONE=0, ERR=0.
- All outputs are registered or decoded from registered state; there are no combinational paths from DIN.
- A committed INIT slot is visible the cycle after the edge that sampled the valid stop bit.
- DONE (or ERR) rises on that same edge. BUSY falls on that edge.
- DIN_VALID=0 cycles are stalls: nothing changes and counters hold. Arbitrary gaps are legal anywhere, including between SYNC and frame data.
- Minimum load length: 8 + 17*NUM_LUTS valid bits.
- Sync overlap: after a non-matching bit, W keeps sliding; no re-arm delay.

## Test plan
- Nominal load, NUM_LUTS=2: send SYNC F2, then 16'hA5C3 with stop 1, then 16'h8001 with stop 1.
  - Required: INIT_FLAT == 32'h8001_A5C3; DONE=1 the cycle after the final stop bit; ERR=0.
  - Required: BUSY high from the cycle after SYNC match until DONE.
- Stop-bit error: after a valid first frame 16'hFFFF, send second frame 16'h1234 with stop 0.
  - Required: ERR=1, DONE=0, slot0=16'hFFFF, slot1 unchanged at 0; further DIN ignored.
- Stalls: same stream as the nominal test with DIN_VALID toggled 1/0/0/1 randomly.
  - Required: results identical to the nominal test; no state change on invalid cycles.
- Sync hunt with noise: send bits 0110_1111_0010 (prefix noise, then SYNC).
  - Required: match occurs exactly on the final 0; the next 16 valid bits are treated as frame 0.
- RESTART mid-frame: assert RESTART after 7 data bits of frame 1, then send a full valid load.
  - Required: ERR and DONE stay 0; state returns to HUNT; the final INIT_FLAT matches the second load only.
- Async reset mid-load: pull RST_N low between clock edges.
  - Required: all outputs go to 0 immediately; after release, a full load completes normally.
